alu_arbiter: RTL and testbench

Shares one `full_alu` datapath between `NUM_REQ` shader-core requesters, such as warp slots or the scalar/vector issue ports. It uses round-robin arbitration, a registered operand stage and a registered result stage with per-requester valid/ready backpressure. It sits between instruction issue and the register-file writeback in each shader core. It sustains one operation per cycle when responses are consumed.

---
 rtl/alu_arbiter_pkg.sv | 41 ++++
 rtl/alu_arbiter_alu.sv | 33 +++
 rtl/alu_arbiter_rr.sv | 41 ++++
 rtl/alu_arbiter.sv | 107 ++++++++++
 tb/tb_alu_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the shader-core ALU arbiter: opcodes, condition codes and stage payloads.
package shader_alu_pkg;

    localparam int ARG_LANES = 4;
    localparam int WORD_W    = 32;
    localparam int SWZ_W     = $clog2(ARG_LANES);

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2,
        NOT = 3'd3,
        AND = 3'd4,
        OR  = 3'd5,
        SHL = 3'd6,
        SRA = 3'd7
    } alu_op_t;

    localparam logic [2:0] NZP_NEG  = 3'b100;
    localparam logic [2:0] NZP_ZERO = 3'b010;
    localparam logic [2:0] NZP_POS  = 3'b001;

    typedef struct packed {
        logic [WORD_W-1:0]                 dest;
        logic [ARG_LANES-1:0][WORD_W-1:0]  arg;
        logic [SWZ_W-1:0]                  swizzle;
        alu_op_t                           op;
    } alu_req_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [2:0]        nzp;
    } alu_resp_t;

    function automatic logic [2:0] nzp_of(input logic [WORD_W-1:0] v);
        if (v[WORD_W-1])  return NZP_NEG;
        else if (v == '0) return NZP_ZERO;
        else              return NZP_POS;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational shader ALU: val_a is the swizzled argument lane, val_b is dest.
module full_alu
    import shader_alu_pkg::*;
(
    input  alu_req_t  req,
    output alu_resp_t resp
);

    logic [WORD_W-1:0] val_a;
    logic [WORD_W-1:0] val_b;
    logic [WORD_W-1:0] res;

    always_comb begin
        val_a = req.arg[req.swizzle];
        val_b = req.dest;
        res   = '0;
        case (req.op)
            ADD: res = val_a + val_b;
            SUB: res = val_a - val_b;
            MUL: res = val_a * val_b;
            NOT: res = ~val_a;
            AND: res = val_a & val_b;
            OR:  res = val_a | val_b;
            // Shift amounts use the whole 32-bit dest, so >=32 fully drains/sign-fills.
            SHL: res = val_a << val_b;
            SRA: res = $unsigned($signed(val_a) >>> val_b);
            default: res = '0;
        endcase
        resp.data = res;
        resp.nzp  = nzp_of(res);
    end

endmodule

// File: rtl/alu_arbiter_rr.sv
// Round-robin arbiter: searches from rr_ptr upward with wrap, pointer moves past the winner on transfer.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            enable,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % N);
            if (enable && !found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (advance)
            rr_ptr <= (grant_id == ID_W'(N-1)) ? '0 : grant_id + 1'b1;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one full_alu among NUM_REQ requesters through an operand stage (S1)
// and a result stage (S2), each with valid/ready flow control.
module alu_arbiter
    import shader_alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*WORD_W-1:0]     req_dest,
    input  logic [NUM_REQ*ARG_LANES*WORD_W-1:0] req_arg,
    input  logic [NUM_REQ*SWZ_W-1:0]      req_swizzle,
    input  logic [NUM_REQ*3-1:0]          req_op,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [WORD_W-1:0]             resp_data,
    output logic [2:0]                    resp_nzp,
    output logic                          busy
);

    localparam int ARG_W = ARG_LANES * WORD_W;

    logic               s1_valid;
    logic [ID_W-1:0]    s1_owner;
    alu_req_t           s1_q;
    logic               s2_valid;
    logic [ID_W-1:0]    s2_owner;
    alu_resp_t          s2_q;

    logic               s2_adv;
    logic               s1_free;
    logic               xfer;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    alu_req_t           req_sel;
    alu_resp_t          alu_out;

    assign s2_adv  = s1_valid & (~s2_valid | resp_ready[s2_owner]);
    assign s1_free = ~s1_valid | s2_adv;
    assign xfer    = |grant;

    // rst_n in the enable keeps req_ready low for the whole reset window.
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_valid),
        .enable   (s1_free & rst_n),
        .advance  (xfer),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        req_sel.dest    = req_dest[grant_id*WORD_W +: WORD_W];
        req_sel.arg     = req_arg[grant_id*ARG_W +: ARG_W];
        req_sel.swizzle = req_swizzle[grant_id*SWZ_W +: SWZ_W];
        req_sel.op      = alu_op_t'(req_op[grant_id*3 +: 3]);
    end

    full_alu u_alu (
        .req  (s1_q),
        .resp (alu_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_owner <= '0;
            s1_q     <= '0;
        end else if (s1_free) begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_owner <= grant_id;
                s1_q     <= req_sel;
            end
        end
    end

    // Result data only changes on an S2 load, so it stays put under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_owner <= '0;
            s2_q     <= '0;
        end else if (s2_adv) begin
            s2_valid <= 1'b1;
            s2_owner <= s1_owner;
            s2_q     <= alu_out;
        end else if (s2_valid && resp_ready[s2_owner]) begin
            s2_valid <= 1'b0;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (s2_valid) resp_valid[s2_owner] = 1'b1;
    end

    assign req_ready = grant;
    assign resp_data = s2_q.data;
    assign resp_nzp  = s2_q.nzp;
    assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single ops, round-robin, backpressure, wrap priority.
module tb_alu_arbiter;

    localparam int NR = 4;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_AND = 3'd4,
                           OP_OR  = 3'd5, OP_SHL = 3'd6, OP_SRA = 3'd7;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [NR*32-1:0]  req_dest;
    logic [NR*128-1:0] req_arg;
    logic [NR*2-1:0]   req_swizzle;
    logic [NR*3-1:0]   req_op;
    logic [31:0]     resp_data;
    logic [2:0]      resp_nzp;
    logic            busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(NR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dest    (req_dest),
        .req_arg     (req_arg),
        .req_swizzle (req_swizzle),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_nzp    (resp_nzp),
        .busy        (busy)
    );

    task automatic set_payload(input int id, input logic [2:0] op, input logic [31:0] a,
                               input logic [1:0] swz, input logic [31:0] b);
        for (int l = 0; l < 4; l++) req_arg[id*128 + l*32 +: 32] = 32'hA5A5_0000 | l;
        req_arg[id*128 + int'(swz)*32 +: 32] = a;
        req_dest[id*32 +: 32]  = b;
        req_swizzle[id*2 +: 2] = swz;
        req_op[id*3 +: 3]      = op;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp_valid: got %b want 0000", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        set_payload(0, OP_ADD, 32'd1, 2'd0, 32'd1);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL inflight_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL midreset_req_ready: got %b want 0000", req_ready); end
        checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL midreset_resp_valid: got %b want 0000", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        checks++; if (resp_data !== 32'd0) begin errors++; $display("FAIL midreset_data: got %h want 0", resp_data); end
        checks++; if (resp_nzp !== 3'b000) begin errors++; $display("FAIL midreset_nzp: got %b want 000", resp_nzp); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checks++; if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
                errors++; $display("FAIL stale_resp%0d: resp_valid=%b busy=%b want 0000/0", k, resp_valid, busy); end
        end
        // rr_ptr must be back at 0: with everyone requesting, requester 0 wins.
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_rr_ptr: got %b want 0001", req_ready); end
        req_valid = 4'b0000;
    endtask

    task automatic test_single();
        logic [2:0]  t_op  [5];
        logic [31:0] t_a   [5];
        logic [1:0]  t_swz [5];
        logic [31:0] t_b   [5];
        logic [31:0] t_exp [5];
        logic [2:0]  t_nzp [5];
        t_op[0] = OP_ADD; t_a[0] = 32'd5;          t_swz[0] = 2; t_b[0] = 32'd7;  t_exp[0] = 32'd12;         t_nzp[0] = 3'b001;
        t_op[1] = OP_SUB; t_a[1] = 32'd5;          t_swz[1] = 2; t_b[1] = 32'd7;  t_exp[1] = 32'hFFFF_FFFE;  t_nzp[1] = 3'b100;
        t_op[2] = OP_SHL; t_a[2] = 32'd1;          t_swz[2] = 0; t_b[2] = 32'd4;  t_exp[2] = 32'd16;         t_nzp[2] = 3'b001;
        t_op[3] = OP_SHL; t_a[3] = 32'd1;          t_swz[3] = 3; t_b[3] = 32'd32; t_exp[3] = 32'd0;          t_nzp[3] = 3'b010;
        t_op[4] = OP_SRA; t_a[4] = 32'h8000_0000;  t_swz[4] = 1; t_b[4] = 32'd4;  t_exp[4] = 32'hF800_0000;  t_nzp[4] = 3'b100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_payload(0, t_op[i], t_a[i], t_swz[i], t_b[i]);
            req_valid = 4'b0001;
            #1;
            checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single%0d_grant: got %b want 0001", i, req_ready); end
            @(negedge clk);
            req_valid = 4'b0000;
            #1;
            checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL single%0d_early: resp_valid=%b want 0000", i, resp_valid); end
            @(negedge clk); #1;
            checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL single%0d_valid: got %b want 0001", i, resp_valid); end
            checks++; if (resp_data !== t_exp[i]) begin errors++; $display("FAIL single%0d_data: got %h want %h", i, resp_data, t_exp[i]); end
            checks++; if (resp_nzp !== t_nzp[i]) begin errors++; $display("FAIL single%0d_nzp: got %b want %b", i, resp_nzp, t_nzp[i]); end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [31:0] exp_d;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < NR; i++) set_payload(i, OP_ADD, 32'(10*i), 2'd0, 32'd1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 4'b1111;
            if (k == 5) req_valid = 4'b0000;
            #1;
            if (k < 5) begin
                exp_g = 4'b0001 << (k % 4);
                checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, exp_g); end
            end
            if (k >= 2) begin
                exp_g = 4'b0001 << ((k-2) % 4);
                exp_d = 32'(10*((k-2) % 4) + 1);
                checks++; if (resp_valid !== exp_g || resp_data !== exp_d) begin
                    errors++; $display("FAIL rr_resp%0d: got %b/%h want %b/%h", k, resp_valid, resp_data, exp_g, exp_d); end
            end
        end
    endtask

    task automatic test_back_to_back();
        set_payload(0, OP_ADD, 32'd3, 2'd0, 32'd4);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 4'b0001;
            if (k == 4) req_valid = 4'b0000;
            #1;
            if (k < 4) begin
                checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_grant%0d: got %b want 0001", k, req_ready); end
            end
            if (k >= 2) begin
                checks++; if (resp_valid !== 4'b0001 || resp_data !== 32'd7) begin
                    errors++; $display("FAIL b2b_resp%0d: got %b/%h want 0001/7", k, resp_valid, resp_data); end
            end
        end
    endtask

    task automatic test_backpressure();
        // rr_ptr is 1 here (last grant went to requester 0).
        @(negedge clk);
        set_payload(1, OP_ADD, 32'd100, 2'd0, 32'd1);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1: got %b want 0010", req_ready); end
        @(negedge clk);
        set_payload(2, OP_ADD, 32'd200, 2'd0, 32'd2);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant2: got %b want 0100", req_ready); end
        @(negedge clk);
        set_payload(0, OP_ADD, 32'd7, 2'd0, 32'd0);
        req_valid  = 4'b0001;
        resp_ready = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready%0d: got %b want 0000", k, req_ready); end
            checks++; if (resp_valid !== 4'b0010 || resp_data !== 32'd101 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_stall_hold%0d: got %b/%h/%b want 0010/65/1", k, resp_valid, resp_data, busy); end
            @(negedge clk);
        end
        resp_ready = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_grant: got %b want 0001", req_ready); end
        checks++; if (resp_valid !== 4'b0010 || resp_data !== 32'd101) begin
            errors++; $display("FAIL bp_resp1: got %b/%h want 0010/65", resp_valid, resp_data); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++; if (resp_valid !== 4'b0100 || resp_data !== 32'd202) begin
            errors++; $display("FAIL bp_resp2: got %b/%h want 0100/ca", resp_valid, resp_data); end
        @(negedge clk); #1;
        checks++; if (resp_valid !== 4'b0001 || resp_data !== 32'd7) begin
            errors++; $display("FAIL bp_resp0: got %b/%h want 0001/7", resp_valid, resp_data); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_wrap();
        // rr_ptr is 1; a lone grant to 2 moves it to 3.
        @(negedge clk);
        set_payload(2, OP_AND, 32'h0000_F0F0, 2'd0, 32'h0000_FF00);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_setup: got %b want 0100", req_ready); end
        @(negedge clk);
        set_payload(1, OP_OR,  32'h0000_000F, 2'd1, 32'h0000_0030);
        set_payload(3, OP_MUL, 32'h0001_0000, 2'd3, 32'h0001_0000);
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first: got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_second: got %b want 0010", req_ready); end
        checks++; if (resp_valid !== 4'b0100 || resp_data !== 32'h0000_F000 || resp_nzp !== 3'b001) begin
            errors++; $display("FAIL wrap_and: got %b/%h/%b want 0100/f000/001", resp_valid, resp_data, resp_nzp); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++; if (resp_valid !== 4'b1000 || resp_data !== 32'd0 || resp_nzp !== 3'b010) begin
            errors++; $display("FAIL wrap_mul: got %b/%h/%b want 1000/0/010", resp_valid, resp_data, resp_nzp); end
        @(negedge clk); #1;
        checks++; if (resp_valid !== 4'b0010 || resp_data !== 32'h0000_003F || resp_nzp !== 3'b001) begin
            errors++; $display("FAIL wrap_or: got %b/%h/%b want 0010/3f/001", resp_valid, resp_data, resp_nzp); end
    endtask

    initial begin
        req_valid   = '0;
        resp_ready  = 4'b1111;
        req_dest    = '0;
        req_arg     = '0;
        req_swizzle = '0;
        req_op      = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
